video_timing_gen: RTL
=====================

// Module: video_timing_gen
// PURPOSE
//  Parametrised raster timing generator and pixel-stream aligner for the HDMI transmitter path.
//  Generates DE/HS/VS/pixel clock for any mode described by its parameters.
//  Pulls pixels from an upstream valid/ready stream during active area and emits registered, sync-aligned output.
//  Detects and flags upstream underflow; I2C transmitter configuration stays in a separate block.
// PARAMETERS
//  CLKS_PER_PIX  4    clk cycles per pixel; even, >=2
//  H_ACTIVE      640  active pixels per line
//  H_FP/H_SYNC/H_BP  16/96/48  horizontal porch/sync widths, pixels
//  V_ACTIVE      480  active lines per frame
//  V_FP/V_SYNC/V_BP  10/2/33   vertical porch/sync widths, lines
//  HS_POL/VS_POL 0/0  sync active level (0 = active-low)
//  DATA_W        24   pixel width (RGB888)
//  BLANK_COLOR   0    pixel driven on underflow
// PORTS
//  clk           in   1       system clock
//  reset         in   1       async, active-high
//  enable        in   1       run raster; stops only at frame end
//  pix_data      in   DATA_W  upstream pixel
//  pix_valid     in   1       upstream pixel valid
//  pix_ready     out  1       pixel consumed this cycle
//  underflow_clr in   1       clears sticky underflow
//  underflow     out  1       sticky: active pixel missing
//  sx            out  CW_H    current column; CW_H = $clog2(H total)
//  sy            out  CW_V    current line; CW_V = $clog2(V total)
//  line_start    out  1       1-clk strobe at sx==0 tick
//  frame_start   out  1       1-clk strobe at sx==0,sy==0 tick
//  hdmi_tx_pclk  out  1       pixel clock
//  hdmi_tx_data  out  DATA_W  pixel out
//  hdmi_tx_de    out  1       data enable
//  hdmi_tx_hs    out  1       hsync
//  hdmi_tx_vs    out  1       vsync
// BEHAVIOUR
//  Reset: all counters 0; sx=sy=0; pix_ready=0; underflow=0; strobes 0; data=0; de=0; hs=!HS_POL; vs=!VS_POL; pclk=0.
//  Tick:
//   - pix_cnt counts 0..CLKS_PER_PIX-1; tick asserts when pix_cnt==CLKS_PER_PIX-1.
//   - pclk=1 for pix_cnt < CLKS_PER_PIX/2, else 0; registered.
//  Counters advance on tick only:
//   - sx wraps at H_TOT-1 = H_ACTIVE+H_FP+H_SYNC+H_BP-1.
//   - sy increments on sx wrap; sy wraps at V_TOT-1.
//  States: IDLE, RUN, DRAIN.
//   - IDLE: counters held 0, outputs at reset values, pix_cnt free-runs. enable=1 -> RUN at next tick; that tick is sx=0,sy=0.
//   - RUN: enable=0 -> DRAIN.
//   - DRAIN: raster continues until the last tick of the frame (sx=H_TOT-1, sy=V_TOT-1), then -> IDLE.
//     enable=1 in DRAIN -> back to RUN, with no raster discontinuity.
//  Decode from (sx,sy), per tick:
//   - act = sx<H_ACTIVE && sy<V_ACTIVE.
//   - hs active for H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC.
//   - vs active for V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC. vs is decoded from sy only, not sx.
//  Handshake:
//   - pix_ready = tick && act && state!=IDLE; combinational, 1 clk per pixel.
//   - Consume when pix_ready&&pix_valid. pix_valid outside pix_ready is ignored; the source must hold data.
//  Output alignment:
//   - On tick, de/hs/vs/data are registered together, 1 clk after the decoding tick, and held for the pixel period.
//   - data = pix_data if consumed; BLANK_COLOR if act&&!pix_valid; 0 when !act.
//  Underflow:
//   - Set on pix_ready&&!pix_valid.
//   - underflow_clr has priority, except a same-cycle set wins.
//  Strobes: line_start/frame_start fire on the tick where the new sx/sy is 0, registered with outputs.
//  Async reset mid-frame: immediate return to reset values; IDLE.
// STRUCTURE
//  Package display_pkg:
//   - timing parameter sets MODE_640x480_60, MODE_1280x720_60 as localparams.
//   - state enum encodings IDLE=0, RUN=1, DRAIN=2.
//  Sub-module video_axis_counter:
//   - instantiated twice (H, V); params ACTIVE/FP/SYNC/BP/POL.
//   - inputs inc, clr. Outputs pos, wrap, act, sync.
// TESTING (CLKS_PER_PIX=4, 640x480 defaults)
//  1 Enable after reset, source always valid:
//    - hs low for 96 px per 800-px line.
//    - vs low lines 490-491 for the whole line.
//    - de high 640x480; frame = 420000 px = 1680000 clk.
//  2 Pattern source (data=sy*1024+sx):
//    - output data at de equals coordinates of the same pixel.
//    - exactly 307200 consumptions per frame.
//  3 Drop pix_valid at (100,5):
//    - output BLANK_COLOR for that pixel; underflow=1 persists.
//    - underflow_clr pulse -> 0.
//    - clr coincident with a new miss -> stays 1.
//  4 Deassert enable at sy=200:
//    - frame completes to sy=524, sx=799, then outputs idle.
//    - re-assert during DRAIN -> no gap, next frame_start on schedule.
//  5 reset pulse mid-line:
//    - all outputs at reset values the same cycle.
//    - after release, first frame_start is exactly one tick after enable.
//  6 HS_POL=VS_POL=1, CLKS_PER_PIX=2:
//    - inverted syncs.
//    - pclk toggles every clk, 50% duty.

Source files
------------

// File: rtl/display_pkg.sv
// Shared timing mode sets and FSM state encoding for the
// HDMI raster timing generator.
package display_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit hs_pol;
        bit vs_pol;
    } timing_t;

    localparam timing_t MODE_640x480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        hs_pol:   1'b0, vs_pol: 1'b0
    };

    localparam timing_t MODE_1280x720_60 = '{
        h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
        hs_pol:   1'b1, vs_pol: 1'b1
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis (horizontal or vertical): position counter with
// active-area and sync-window decode.
// Ports:
//   clk, rst   clock, async active-high reset
//   inc        advance position by one (wraps at total-1)
//   clr        force position to 0 (priority over inc)
//   pos        current position
//   wrap       position is the last of the axis
//   act        position is inside the active area
//   sync       sync output at its configured polarity
module video_axis_counter
    import display_pkg::*;
#(
    parameter int  ACTIVE = 640,
    parameter int  FP     = 16,
    parameter int  SYNC   = 96,
    parameter int  BP     = 48,
    parameter bit  POL    = 1'b0,
    localparam int TOT    = ACTIVE + FP + SYNC + BP,
    localparam int CW     = $clog2(TOT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] pos,
    output logic          wrap,
    output logic          act,
    output logic          sync
);

    logic in_sync;

    assign wrap    = (int'(pos) == TOT - 1);
    assign act     = (int'(pos) < ACTIVE);
    assign in_sync = (int'(pos) >= ACTIVE + FP) &&
                     (int'(pos) <  ACTIVE + FP + SYNC);
    assign sync    = in_sync ? POL : !POL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
        end else if (clr) begin
            pos <= '0;
        end else if (inc) begin
            pos <= wrap ? '0 : pos + 1'b1;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator and pixel-stream aligner for the HDMI
// transmitter path.
// Ports:
//   clk, reset        clock, async active-high reset
//   enable            run the raster; stopping waits for frame end
//   pix_data/valid    upstream pixel stream
//   pix_ready         pixel consumed this cycle (1 clk per pixel)
//   underflow_clr     clears the sticky underflow flag
//   underflow         sticky: an active pixel was missing
//   sx, sy            current column / line
//   line_start        1-clk strobe, new line begins
//   frame_start       1-clk strobe, new frame begins
//   hdmi_tx_*         registered, mutually aligned video outputs
module video_timing_gen
    import display_pkg::*;
#(
    parameter int  CLKS_PER_PIX = 4,
    parameter int  H_ACTIVE     = MODE_640x480_60.h_active,
    parameter int  H_FP         = MODE_640x480_60.h_fp,
    parameter int  H_SYNC       = MODE_640x480_60.h_sync,
    parameter int  H_BP         = MODE_640x480_60.h_bp,
    parameter int  V_ACTIVE     = MODE_640x480_60.v_active,
    parameter int  V_FP         = MODE_640x480_60.v_fp,
    parameter int  V_SYNC       = MODE_640x480_60.v_sync,
    parameter int  V_BP         = MODE_640x480_60.v_bp,
    parameter bit  HS_POL       = MODE_640x480_60.hs_pol,
    parameter bit  VS_POL       = MODE_640x480_60.vs_pol,
    parameter int  DATA_W       = 24,
    parameter logic [DATA_W-1:0] BLANK_COLOR = '0,
    localparam int H_TOT        = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOT        = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int CW_H         = $clog2(H_TOT),
    localparam int CW_V         = $clog2(V_TOT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              underflow_clr,
    output logic              underflow,
    output logic [CW_H-1:0]   sx,
    output logic [CW_V-1:0]   sy,
    output logic              line_start,
    output logic              frame_start,
    output logic              hdmi_tx_pclk,
    output logic [DATA_W-1:0] hdmi_tx_data,
    output logic              hdmi_tx_de,
    output logic              hdmi_tx_hs,
    output logic              hdmi_tx_vs
);

    localparam int PC_W = (CLKS_PER_PIX > 1) ? $clog2(CLKS_PER_PIX) : 1;

    state_t          state;
    logic [PC_W-1:0] pix_cnt;
    logic            tick;
    logic            run;
    logic            h_inc, v_inc, cnt_clr;
    logic            h_wrap, v_wrap, h_act, v_act;
    logic            h_sync, v_sync;
    logic            act, consume, frame_end;
    logic            start_run, going_idle;

    // Pixel divider free-runs in every state so the enable-to-first-
    // frame latency is always one pixel period at most.
    assign tick = (pix_cnt == PC_W'(CLKS_PER_PIX - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt <= '0;
        end else begin
            pix_cnt <= tick ? '0 : pix_cnt + 1'b1;
        end
    end

    assign run     = (state != IDLE);
    assign h_inc   = tick && run;
    assign v_inc   = h_inc && h_wrap;
    assign cnt_clr = !run;

    video_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL)
    ) u_h (
        .clk  (clk),
        .rst  (reset),
        .inc  (h_inc),
        .clr  (cnt_clr),
        .pos  (sx),
        .wrap (h_wrap),
        .act  (h_act),
        .sync (h_sync)
    );

    video_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL)
    ) u_v (
        .clk  (clk),
        .rst  (reset),
        .inc  (v_inc),
        .clr  (cnt_clr),
        .pos  (sy),
        .wrap (v_wrap),
        .act  (v_act),
        .sync (v_sync)
    );

    assign act       = h_act && v_act;
    assign frame_end = h_wrap && v_wrap;
    assign pix_ready = tick && act && run;
    assign consume   = pix_ready && pix_valid;

    assign start_run  = (state == IDLE) && tick && enable;
    // Last tick of a draining frame: the raster wraps to 0,0 but
    // no new line/frame begins.
    assign going_idle = (state == DRAIN) && !enable &&
                        tick && frame_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            underflow    <= 1'b0;
            hdmi_tx_pclk <= 1'b0;
            hdmi_tx_data <= '0;
            hdmi_tx_de   <= 1'b0;
            hdmi_tx_hs   <= !HS_POL;
            hdmi_tx_vs   <= !VS_POL;
        end else begin
            hdmi_tx_pclk <= (pix_cnt < PC_W'(CLKS_PER_PIX / 2));
            line_start   <= start_run ||
                            (h_inc && h_wrap && !going_idle);
            frame_start  <= start_run ||
                            (h_inc && frame_end && !going_idle);

            // A miss in the same cycle as a clear keeps the flag set.
            if (pix_ready && !pix_valid) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end

            if (tick) begin
                if (run) begin
                    hdmi_tx_de   <= act;
                    hdmi_tx_hs   <= h_sync;
                    hdmi_tx_vs   <= v_sync;
                    hdmi_tx_data <= consume ? pix_data :
                                    act     ? BLANK_COLOR : '0;
                end else begin
                    hdmi_tx_de   <= 1'b0;
                    hdmi_tx_hs   <= !HS_POL;
                    hdmi_tx_vs   <= !VS_POL;
                    hdmi_tx_data <= '0;
                end
            end

            unique case (state)
                IDLE: begin
                    if (start_run) state <= RUN;
                end
                RUN: begin
                    if (!enable) state <= DRAIN;
                end
                DRAIN: begin
                    if (enable) begin
                        state <= RUN;
                    end else if (going_idle) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
